// File: rtl/meas_pulse_gen.sv
// ---------------------------------------------------------------------------
// meas_pulse_gen
//
// Programmable pulse-train generator. Produces a burst of periods, each of
// which is high for a programmed number of clk cycles and low for the rest
// of the programmed period. It is the stimulus source for the measurement
// path, so the generated waveform has to be cycle exact.
//
// Optional feature macro: MEAS_PULSE_GEN_POLARITY_EN
//   When defined, adds input pol_i. A 1 latched at start inverts the active
//   waveform, and pulse_o rests at the latched polarity while idle.
//
// Parameters:
//   CNT_W : width of the period and high-time settings (clk cycles)
//   NUM_W : width of the period-count request and status
//
// Ports:
//   clk          system clock
//   reset_i      synchronous reset, active high
//   start_i      burst request, sampled only in IDLE
//   period_i     period in clk cycles, latched on an accepted start
//   high_i       high time in clk cycles, latched on an accepted start
//   num_i        number of periods, 0 = continuous until stop_i
//   stop_i       graceful stop at the next period boundary (RUN only)
//   pol_i        output polarity (only with MEAS_PULSE_GEN_POLARITY_EN)
//   pulse_o      generated signal
//   busy_o       burst in progress
//   done_o       one-cycle pulse when a burst completes
//   pulse_cnt_o  number of completed periods of the current/last burst
//   cfg_err_o    one-cycle pulse when a start is rejected
//
// Handshake: a start is accepted when start_i=1 at an edge while the FSM is
// in IDLE and the settings are legal (period_i>=2, 1<=high_i<period_i).
// busy_o rises on the next cycle together with the first high phase, and
// stays high until the cycle that carries the one-cycle done_o pulse. A
// start that is illegal raises cfg_err_o for one cycle instead. start_i is
// ignored while busy_o=1; it is honoured in the cycle done_o is high, so
// bursts can run back to back.
// ---------------------------------------------------------------------------
module meas_pulse_gen #(
    parameter int CNT_W = 24,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] high_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic             stop_i,
`ifdef MEAS_PULSE_GEN_POLARITY_EN
    input  logic             pol_i,
`endif
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] pulse_cnt_o,
    output logic             cfg_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] period_q,    period_d;
    logic [CNT_W-1:0] high_q,      high_d;
    logic [NUM_W-1:0] num_q,       num_d;
    logic [CNT_W-1:0] phase_q,     phase_d;
    logic             stop_pend_q, stop_pend_d;
    logic             pulse_q,     pulse_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [NUM_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             cfg_err_q,   cfg_err_d;

    // Polarity actually in use and the polarity a start would latch.
    logic pol_q;
    logic pol_start;

`ifdef MEAS_PULSE_GEN_POLARITY_EN
    logic pol_d;
    assign pol_start = pol_i;
`else
    assign pol_q     = 1'b0;
    assign pol_start = 1'b0;
`endif

    logic             start_ok;
    logic [CNT_W-1:0] phase_inc;
    logic [NUM_W-1:0] cnt_inc;
    logic             period_end;
    logic             burst_end;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        high_d      = high_q;
        num_d       = num_q;
        phase_d     = phase_q;
        stop_pend_d = stop_pend_q;
        pulse_d     = pulse_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pulse_cnt_d = pulse_cnt_q;
        cfg_err_d   = 1'b0;
`ifdef MEAS_PULSE_GEN_POLARITY_EN
        pol_d       = pol_q;
`endif

        // period_i>=2 guarantees high_i<period_i leaves room for a low phase.
        start_ok   = (period_i >= CNT_W'(2)) && (high_i != '0) && (high_i < period_i);

        // phase_q is the position inside the current period, 0 at its start.
        phase_inc  = phase_q + CNT_W'(1);
        cnt_inc    = pulse_cnt_q + NUM_W'(1);
        period_end = (phase_q == (period_q - CNT_W'(1)));

        // A stop raised on the last cycle of a period still ends that period.
        burst_end  = period_end &&
                     (((num_q != '0) && (cnt_inc == num_q)) || stop_pend_q || stop_i);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d     = RUN;
                        period_d    = period_i;
                        high_d      = high_i;
                        num_d       = num_i;
                        phase_d     = '0;
                        stop_pend_d = 1'b0;
                        pulse_cnt_d = '0;
                        busy_d      = 1'b1;
                        pulse_d     = ~pol_start;
`ifdef MEAS_PULSE_GEN_POLARITY_EN
                        pol_d       = pol_start;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (period_end) begin
                    pulse_cnt_d = cnt_inc;
                    phase_d     = '0;
                    if (burst_end) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        stop_pend_d = 1'b0;
                        pulse_d     = pol_q;
                    end else begin
                        pulse_d = ~pol_q;
                    end
                end else begin
                    phase_d = phase_inc;
                    pulse_d = (phase_inc < high_q) ^ pol_q;
                    if (stop_i) begin
                        stop_pend_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            period_q    <= '0;
            high_q      <= '0;
            num_q       <= '0;
            phase_q     <= '0;
            stop_pend_q <= 1'b0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pulse_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
`ifdef MEAS_PULSE_GEN_POLARITY_EN
            pol_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            high_q      <= high_d;
            num_q       <= num_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pulse_cnt_q <= pulse_cnt_d;
            cfg_err_q   <= cfg_err_d;
`ifdef MEAS_PULSE_GEN_POLARITY_EN
            pol_q       <= pol_d;
`endif
        end
    end

    assign pulse_o     = pulse_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pulse_cnt_o = pulse_cnt_q;
    assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_meas_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_meas_pulse_gen
//
// Directed bench for meas_pulse_gen. Inputs change and outputs are sampled
// on the falling edge; "cycle j" below is the j-th cycle after the rising
// edge that sampled start_i.
// ---------------------------------------------------------------------------
module tb_meas_pulse_gen;

    localparam int CNT_W = 24;
    localparam int NUM_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_i;
    logic             start_i;
    logic [CNT_W-1:0] period_i;
    logic [CNT_W-1:0] high_i;
    logic [NUM_W-1:0] num_i;
    logic             stop_i;
`ifdef MEAS_PULSE_GEN_POLARITY_EN
    logic             pol_i;
`endif
    logic             pulse_o;
    logic             busy_o;
    logic             done_o;
    logic [NUM_W-1:0] pulse_cnt_o;
    logic             cfg_err_o;

    meas_pulse_gen #(
        .CNT_W(CNT_W),
        .NUM_W(NUM_W)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .period_i   (period_i),
        .high_i     (high_i),
        .num_i      (num_i),
        .stop_i     (stop_i),
`ifdef MEAS_PULSE_GEN_POLARITY_EN
        .pol_i      (pol_i),
`endif
        .pulse_o    (pulse_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pulse_cnt_o(pulse_cnt_o),
        .cfg_err_o  (cfg_err_o)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int j,
                              input logic exp_pulse, input logic exp_busy,
                              input logic exp_done, input int exp_cnt,
                              input logic exp_err);
        check($sformatf("%s.c%0d.pulse", tag, j), 32'(pulse_o), 32'(exp_pulse));
        check($sformatf("%s.c%0d.busy",  tag, j), 32'(busy_o),  32'(exp_busy));
        check($sformatf("%s.c%0d.done",  tag, j), 32'(done_o),  32'(exp_done));
        check($sformatf("%s.c%0d.cnt",   tag, j), 32'(pulse_cnt_o), 32'(exp_cnt));
        check($sformatf("%s.c%0d.err",   tag, j), 32'(cfg_err_o), 32'(exp_err));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_start(input int p, input int h, input int n);
        period_i = CNT_W'(p);
        high_i   = CNT_W'(h);
        num_i    = NUM_W'(n);
        start_i  = 1'b1;
    endtask

    int bad_p[3] = '{1, 5, 5};
    int bad_h[3] = '{1, 5, 0};

    initial begin
        reset_i  = 1'b1;
        start_i  = 1'b0;
        period_i = '0;
        high_i   = '0;
        num_i    = '0;
        stop_i   = 1'b0;
`ifdef MEAS_PULSE_GEN_POLARITY_EN
        pol_i    = 1'b0;
`endif
        tick();
        tick();
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        reset_i = 1'b0;
        tick();
        check_outs("idle", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // ---- 10/3 x4: 3 high / 7 low, done in cycle 41 ----
        set_start(10, 3, 4);
        for (int j = 1; j <= 42; j++) begin
            tick();
            start_i = 1'b0;
            if (j <= 40)
                check_outs("b10x4", j, ((j - 1) % 10) < 3, 1'b1, 1'b0, (j - 1) / 10, 1'b0);
            else
                check_outs("b10x4", j, 1'b0, 1'b0, (j == 41), 4, 1'b0);
        end

        // ---- rejected configurations ----
        for (int i = 0; i < 3; i++) begin
            set_start(bad_p[i], bad_h[i], 2);
            tick();
            start_i = 1'b0;
            check_outs($sformatf("bad%0d", i), 1, 1'b0, 1'b0, 1'b0, 4, 1'b1);
            tick();
            check_outs($sformatf("bad%0d", i), 2, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        end

        // ---- continuous 8/4, stop in cycle 19 -> ends at cycle-24 boundary ----
        set_start(8, 4, 0);
        for (int j = 1; j <= 27; j++) begin
            tick();
            start_i = 1'b0;
            if (j <= 24)
                check_outs("stop", j, ((j - 1) % 8) < 4, 1'b1, 1'b0, (j - 1) / 8, 1'b0);
            else
                check_outs("stop", j, 1'b0, 1'b0, (j == 25), 3, 1'b0);
            stop_i = (j == 19);
        end

        // ---- stop_i while idle is ignored ----
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check_outs("idle_stop", 1, 1'b0, 1'b0, 1'b0, 3, 1'b0);

        // ---- 6/2 x3, start and setting changes during RUN ignored,
        //      then a back-to-back 4/1 x1 started while done_o is high ----
        set_start(6, 2, 3);
        for (int j = 1; j <= 25; j++) begin
            tick();
            start_i = 1'b0;
            if (j <= 18)
                check_outs("busy_start", j, ((j - 1) % 6) < 2, 1'b1, 1'b0, (j - 1) / 6, 1'b0);
            else if (j == 19)
                check_outs("busy_start", j, 1'b0, 1'b0, 1'b1, 3, 1'b0);
            else if (j <= 23)
                check_outs("b2b", j, (j == 20), 1'b1, 1'b0, 0, 1'b0);
            else
                check_outs("b2b", j, 1'b0, 1'b0, (j == 24), 1, 1'b0);
            if (j == 4) set_start(20, 9, 1);
            if (j == 5) high_i = CNT_W'(1);
            if (j == 19) set_start(4, 1, 1);
        end

        // ---- reset in cycle 5 of a 10/3 burst, then a fresh 5/2 x1 ----
        set_start(10, 3, 2);
        for (int j = 1; j <= 7; j++) begin
            tick();
            start_i = 1'b0;
            if (j <= 5)
                check_outs("rst_mid", j, (j - 1) < 3, 1'b1, 1'b0, 0, 1'b0);
            else
                check_outs("rst_mid", j, 1'b0, 1'b0, 1'b0, 0, 1'b0);
            reset_i = (j == 5);
        end
        set_start(5, 2, 1);
        for (int j = 1; j <= 7; j++) begin
            tick();
            start_i = 1'b0;
            if (j <= 5)
                check_outs("after_rst", j, (j - 1) < 2, 1'b1, 1'b0, 0, 1'b0);
            else
                check_outs("after_rst", j, 1'b0, 1'b0, (j == 6), 1, 1'b0);
        end

`ifdef MEAS_PULSE_GEN_POLARITY_EN
        // ---- inverted 4/1 x2: 0,1,1,1,0,1,1,1 then rests at 1 ----
        pol_i = 1'b1;
        set_start(4, 1, 2);
        for (int j = 1; j <= 10; j++) begin
            tick();
            start_i = 1'b0;
            if (j <= 8)
                check_outs("pol", j, ((j - 1) % 4) >= 1, 1'b1, 1'b0, (j - 1) / 4, 1'b0);
            else
                check_outs("pol", j, 1'b1, 1'b0, (j == 9), 2, 1'b0);
        end
        pol_i = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/meas_pulse_gen.md
Name: meas_pulse_gen

Overview:
Programmable pulse-train generator: the transmit/stimulus end of the measurement path. It drives a period/high-time controlled digital signal into the measurement input of meas_top_system so the measured values can be checked against known settings. A start/busy/done handshake controls it from a bench sequencer or an on-chip controller. Single clock domain.

Parameters:
CNT_W, 24, width of the period and high-time counters, in clk cycles.
NUM_W, 16, width of the pulse-count request and status.

Ports:
clk  input  1  system clock
reset_i  input  1  synchronous reset, active high
start_i  input  1  request a burst; sampled only in IDLE
period_i  input  CNT_W  period in clk cycles; latched on an accepted start
high_i  input  CNT_W  high time in clk cycles; latched on an accepted start
num_i  input  NUM_W  number of periods; 0 = continuous until stop
stop_i  input  1  request a graceful stop at the next period boundary
pulse_o  output  1  generated signal
busy_o  output  1  burst in progress
done_o  output  1  one-cycle pulse when a burst completes
pulse_cnt_o  output  NUM_W  number of completed periods
cfg_err_o  output  1  one-cycle pulse when a start is rejected

Behaviour:
- Interface: one clock, clk. Reset is reset_i, synchronous and active high. All outputs are registered.
- Reset values: pulse_o=0, busy_o=0, done_o=0, pulse_cnt_o=0, cfg_err_o=0. The FSM goes to IDLE.
- Reset asserted mid-burst: all outputs return to reset values on the next edge. No done_o is generated.
- FSM states: IDLE and RUN.
- Start validity check, applied in IDLE when start_i=1 at edge k:
  - Valid only if period_i>=2 and 1<=high_i<=period_i-1. Unsigned compare at CNT_W width.
  - Invalid: cfg_err_o=1 for cycle k+1 only. The FSM stays in IDLE and pulse_cnt_o is unchanged.
  - Valid: latch period, high and num; clear pulse_cnt_o to 0; go to RUN. busy_o=1 and pulse_o=1 from cycle k+1.
- Waveform per period, with P=period and H=high, relative to period start cycle s:
  - pulse_o=1 for cycles s..s+H-1.
  - pulse_o=0 for cycles s+H..s+P-1.
  - The next period starts at s+P with no gap cycle.
- Period count:
  - pulse_cnt_o increments by 1 at the end of every period; the new value is visible at s+P.
  - In continuous mode it wraps from 2^NUM_W-1 to 0.
  - It holds its value after the burst ends until the next accepted start.
- Burst end (num>0): when pulse_cnt_o would reach num, in that cycle busy_o=0, done_o=1 (one cycle), pulse_o=0, and the FSM returns to IDLE.
- stop_i:
  - Sampled in RUN at any cycle and held internally as pending.
  - The burst ends at the next period boundary, exactly like a num completion: done_o pulse, and pulse_cnt_o includes the finished period.
  - If the stop and a num completion fall on the same boundary, only one done_o is issued.
  - stop_i in IDLE is ignored.
- start_i while busy_o=1 is ignored: no cfg_err_o, and latched settings are unchanged.
- Changes to period_i, high_i or num_i during RUN have no effect.
- A start accepted in the same cycle that done_o is high (i.e. back-to-back after completion) is allowed: the new burst begins on the following cycle.

Optional Feature:
- Macro: MEAS_PULSE_GEN_POLARITY_EN.
- When defined:
  - Adds input pol_i (1 bit), latched on an accepted start.
  - pol_i=1 inverts the active waveform: pulse_o is 0 in the high phase and 1 in the low phase.
  - The idle and reset level of pulse_o equals the latched polarity. The reset value is 0 and the latch value is 0.
- When undefined: the port is absent and the behaviour is non-inverted as above.

Test Plan:
- Reset, then start with period=10, high=3, num=4 -> pulse_o is 3 high / 7 low ×4; busy_o high for 40 cycles; done_o high in cycle 41 after start; pulse_cnt_o=4.
- Start with period=1, high=1; then period=5, high=5; then high=0 -> cfg_err_o pulses once each, busy_o stays 0, pulse_o stays 0.
- Start with period=8, high=4, num=0; assert stop_i in cycle 19 -> burst ends at the cycle-24 boundary; done_o pulses once; pulse_cnt_o=3.
- During a burst with period=6, high=2, num=3: assert start_i with period=20, and change high_i -> waveform is unchanged at 6/2; no cfg_err_o; done_o after 18 cycles.
- Assert reset_i in cycle 5 of a 10/3 burst -> next cycle all outputs are 0 and there is no done_o; a new start then works normally.
- With MEAS_PULSE_GEN_POLARITY_EN defined, pol_i=1, period=4, high=1, num=2 -> pulse_o pattern 0,1,1,1,0,1,1,1, then holds 1 in idle; done_o at cycle 9.
